// File: rtl/decode_rename_dispatch_pkg.sv
// Shared types and constants for the decode/rename/dispatch front-end slice.
//   uop_pkg          : micro-op tag encoding and lane count
//   cluster_pkg      : execution cluster select plus per-uop capability/cluster maps
//   decode_table_pkg : opcode match constants used by the combinational decoder
package uop_pkg;
    localparam int MAX_UOPS = 2;

    typedef enum logic [5:0] {
        UOP_INT_ALU       = 6'd0,
        UOP_PREFIX_SELECT = 6'd1,
        UOP_ST_U8         = 6'd2,
        UOP_PACK_ADD_SAT  = 6'd3,
        UOP_CAP_JUMP      = 6'd4,
        UOP_LINK          = 6'd5,
        UOP_CAP_LOAN_END  = 6'd6,
        UOP_MEM_PREFETCH  = 6'd7,
        UOP_LR128         = 6'd8
    } uop_tag_t;
endpackage

package cluster_pkg;
    import uop_pkg::*;

    typedef enum logic [1:0] {
        CLUSTER_ALU        = 2'd0,
        CLUSTER_CAPABILITY = 2'd1,
        CLUSTER_LSQ        = 2'd2,
        CLUSTER_ASYNC      = 2'd3
    } cluster_sel_e;

    function automatic logic is_capability(uop_tag_t uop);
        case (uop)
            UOP_PREFIX_SELECT,
            UOP_CAP_JUMP,
            UOP_LINK,
            UOP_CAP_LOAN_END: return 1'b1;
            default:          return 1'b0;
        endcase
    endfunction

    function automatic cluster_sel_e cluster_of(uop_tag_t uop);
        if (is_capability(uop)) return CLUSTER_CAPABILITY;
        case (uop)
            UOP_ST_U8,
            UOP_LR128:        return CLUSTER_LSQ;
            UOP_MEM_PREFETCH: return CLUSTER_ASYNC;
            default:          return CLUSTER_ALU;
        endcase
    endfunction
endpackage

package decode_table_pkg;
    // Short form matches on bits [11:4].
    localparam logic [7:0]  SHORT_PREFIX_SELECT = 8'hEE;
    localparam logic [7:0]  SHORT_ST_U8         = 8'h89;
    // Long form selects on bits [23:20].
    localparam logic [3:0]  LONG_PACK_ADD_SAT   = 4'h5;
    localparam logic [3:0]  LONG_CAP_JUMP_LINK  = 4'h4;
    localparam logic [3:0]  LONG_MEM_PREFETCH   = 4'h6;
    localparam logic [3:0]  LONG_CAP_LOAN_END   = 4'h9;
    localparam logic [11:0] LONG_CAP_LOAN_LOW   = 12'hFF1;
    localparam logic [3:0]  LONG_LR128          = 4'hC;
endpackage

// File: rtl/decode_rename_dispatch_if.sv
// Bundle of the instruction input, combinational decode outputs and the
// registered rename/dispatch outputs of decode_rename_dispatch.
//   slave  : design side (drives decode/dispatch results, reads the instruction)
//   master : environment side (drives the instruction, observes everything else)
interface decode_rename_dispatch_if #(
    parameter int MAX_UOPS = 2
);
    logic [23:0]                instr_i;
    logic                       instr_is_long_i;
    uop_pkg::uop_tag_t          uop_tag0_o;
    uop_pkg::uop_tag_t          uop_tag1_o;
    logic [1:0]                 uop_count_o;
    logic                       match_valid_o;
    logic                       rename_ready_o;
    logic                       dispatch_valid_o;
    uop_pkg::uop_tag_t          dispatch_uop0_o;
    uop_pkg::uop_tag_t          dispatch_uop1_o;
    logic [1:0]                 dispatch_uop_count_o;
    logic                       dispatch_ready_o;
    logic [MAX_UOPS-1:0]        lane_is_capability_o;
    logic [2*MAX_UOPS-1:0]      lane_cluster_o;
    logic [15:0]                capability_issued_count_o;
    logic [15:0]                alu_issue_count_o;
    logic [15:0]                capability_issue_count_o;
    logic [15:0]                lsq_issue_count_o;
    logic [15:0]                async_issue_count_o;

    modport slave (
        input  instr_i, instr_is_long_i,
        output uop_tag0_o, uop_tag1_o, uop_count_o, match_valid_o,
        output rename_ready_o, dispatch_valid_o, dispatch_uop0_o, dispatch_uop1_o,
        output dispatch_uop_count_o, dispatch_ready_o,
        output lane_is_capability_o, lane_cluster_o,
        output capability_issued_count_o, alu_issue_count_o,
        output capability_issue_count_o, lsq_issue_count_o, async_issue_count_o
    );

    modport master (
        output instr_i, instr_is_long_i,
        input  uop_tag0_o, uop_tag1_o, uop_count_o, match_valid_o,
        input  rename_ready_o, dispatch_valid_o, dispatch_uop0_o, dispatch_uop1_o,
        input  dispatch_uop_count_o, dispatch_ready_o,
        input  lane_is_capability_o, lane_cluster_o,
        input  capability_issued_count_o, alu_issue_count_o,
        input  capability_issue_count_o, lsq_issue_count_o, async_issue_count_o
    );
endinterface

// File: rtl/decode_rename_dispatch_decode_table.sv
// Combinational instruction decoder: 12-bit short or 24-bit long form into
// up to two micro-op tags.
//   instr_i         : instruction (short form uses [11:0])
//   instr_is_long_i : 1 selects the long form
//   uop_tag0_o/1_o  : decoded tags, INT_ALU when unused
//   uop_count_o     : number of valid tags (0..2)
//   match_valid_o   : encoding recognised
module decode_table
    import uop_pkg::*;
    import decode_table_pkg::*;
(
    input  logic [23:0] instr_i,
    input  logic        instr_is_long_i,
    output uop_tag_t    uop_tag0_o,
    output uop_tag_t    uop_tag1_o,
    output logic [1:0]  uop_count_o,
    output logic        match_valid_o
);

    // Bits [19:12] carry operands that this slice never looks at.
    logic unused_operand_bits;
    assign unused_operand_bits = ^instr_i[19:12];

    always_comb begin
        uop_tag0_o    = UOP_INT_ALU;
        uop_tag1_o    = UOP_INT_ALU;
        uop_count_o   = 2'd0;
        match_valid_o = 1'b0;

        if (!instr_is_long_i) begin
            case (instr_i[11:4])
                SHORT_PREFIX_SELECT: begin
                    uop_tag0_o    = UOP_PREFIX_SELECT;
                    uop_count_o   = 2'd1;
                    match_valid_o = 1'b1;
                end
                SHORT_ST_U8: begin
                    uop_tag0_o    = UOP_ST_U8;
                    uop_count_o   = 2'd1;
                    match_valid_o = 1'b1;
                end
                default: ;
            endcase
        end else begin
            case (instr_i[23:20])
                LONG_PACK_ADD_SAT: begin
                    uop_tag0_o    = UOP_PACK_ADD_SAT;
                    uop_count_o   = 2'd1;
                    match_valid_o = 1'b1;
                end
                LONG_CAP_JUMP_LINK: begin
                    uop_tag0_o    = UOP_CAP_JUMP;
                    uop_tag1_o    = UOP_LINK;
                    uop_count_o   = 2'd2;
                    match_valid_o = 1'b1;
                end
                LONG_MEM_PREFETCH: begin
                    uop_tag0_o    = UOP_MEM_PREFETCH;
                    uop_count_o   = 2'd1;
                    match_valid_o = 1'b1;
                end
                LONG_CAP_LOAN_END: begin
                    if (instr_i[11:0] == LONG_CAP_LOAN_LOW) begin
                        uop_tag0_o    = UOP_CAP_LOAN_END;
                        uop_count_o   = 2'd1;
                        match_valid_o = 1'b1;
                    end
                end
                LONG_LR128: begin
                    uop_tag0_o    = UOP_LR128;
                    uop_count_o   = 2'd1;
                    match_valid_o = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/decode_rename_dispatch.sv
// Front-end slice: combinational decode, one-entry rename register and a
// dispatch classifier with per-cluster issue counters.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   bus (slave)  : instruction in; decode tags/count/match (combinational);
//                  rename_ready; registered dispatch tags/count/valid/ready;
//                  per-lane capability flag and cluster; 16-bit wrap counters
// Only MAX_UOPS = 2 is supported.
module decode_rename_dispatch
    import uop_pkg::*;
    import cluster_pkg::*;
#(
    parameter int MAX_UOPS = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    decode_rename_dispatch_if.slave  bus
);

    uop_tag_t     dec_tag0;
    uop_tag_t     dec_tag1;
    logic [1:0]   dec_count;
    logic         dec_match;

    decode_table u_decode_table (
        .instr_i         (bus.instr_i),
        .instr_is_long_i (bus.instr_is_long_i),
        .uop_tag0_o      (dec_tag0),
        .uop_tag1_o      (dec_tag1),
        .uop_count_o     (dec_count),
        .match_valid_o   (dec_match)
    );

    logic                 valid_q;
    uop_tag_t             tag_q     [MAX_UOPS];
    logic [1:0]           count_q;
    logic [MAX_UOPS-1:0]  cap_q;
    logic [15:0]          cap_issued_q;
    logic [15:0]          clus_cnt_q [4];

    uop_tag_t             tag_d     [MAX_UOPS];
    logic [MAX_UOPS-1:0]  cap_d;
    logic [1:0]           cap_add;
    cluster_sel_e         lane_clus [MAX_UOPS];
    logic [1:0]           clus_inc  [4];

    logic dispatch_ready;
    logic rename_ready;
    logic accept;
    logic dispatch_fire;

    // Dispatch is never back-pressured once out of reset.
    assign dispatch_ready = !rst_i;
    assign rename_ready   = !valid_q || dispatch_ready;
    assign accept         = dec_match && rename_ready;
    assign dispatch_fire  = valid_q && dispatch_ready;

    // Rename capture values: lanes beyond the decoded count are forced idle.
    always_comb begin
        uop_tag_t dec_tag [MAX_UOPS];
        dec_tag[0] = dec_tag0;
        dec_tag[1] = dec_tag1;
        cap_add    = 2'd0;
        for (int i = 0; i < MAX_UOPS; i++) begin
            if (2'(i) < dec_count) begin
                tag_d[i] = dec_tag[i];
                cap_d[i] = is_capability(dec_tag[i]);
            end else begin
                tag_d[i] = UOP_INT_ALU;
                cap_d[i] = 1'b0;
            end
            cap_add = cap_add + {1'b0, cap_d[i]};
        end
    end

    // Per-lane cluster routing and per-cluster issue increments.
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            clus_inc[c] = 2'd0;
        end
        for (int i = 0; i < MAX_UOPS; i++) begin
            lane_clus[i] = CLUSTER_ALU;
            if (valid_q && (2'(i) < count_q)) begin
                lane_clus[i] = cluster_of(tag_q[i]);
                clus_inc[lane_clus[i]] = clus_inc[lane_clus[i]] + 2'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q      <= 1'b0;
            count_q      <= 2'd0;
            cap_q        <= '0;
            cap_issued_q <= 16'd0;
            for (int i = 0; i < MAX_UOPS; i++) begin
                tag_q[i] <= UOP_INT_ALU;
            end
            for (int c = 0; c < 4; c++) begin
                clus_cnt_q[c] <= 16'd0;
            end
        end else begin
            if (accept) begin
                valid_q      <= 1'b1;
                count_q      <= dec_count;
                cap_q        <= cap_d;
                cap_issued_q <= cap_issued_q + 16'(cap_add);
                for (int i = 0; i < MAX_UOPS; i++) begin
                    tag_q[i] <= tag_d[i];
                end
            end else if (dispatch_fire) begin
                valid_q <= 1'b0;
                count_q <= 2'd0;
                cap_q   <= '0;
                for (int i = 0; i < MAX_UOPS; i++) begin
                    tag_q[i] <= UOP_INT_ALU;
                end
            end
            if (dispatch_fire) begin
                for (int c = 0; c < 4; c++) begin
                    clus_cnt_q[c] <= clus_cnt_q[c] + 16'(clus_inc[c]);
                end
            end
        end
    end

    always_comb begin
        bus.lane_cluster_o = '0;
        for (int i = 0; i < MAX_UOPS; i++) begin
            bus.lane_cluster_o[2*i +: 2] = lane_clus[i];
        end
    end

    assign bus.uop_tag0_o                = dec_tag0;
    assign bus.uop_tag1_o                = dec_tag1;
    assign bus.uop_count_o               = dec_count;
    assign bus.match_valid_o             = dec_match;
    assign bus.rename_ready_o            = rename_ready;
    assign bus.dispatch_ready_o          = dispatch_ready;
    assign bus.dispatch_valid_o          = valid_q;
    assign bus.dispatch_uop0_o           = tag_q[0];
    assign bus.dispatch_uop1_o           = tag_q[1];
    assign bus.dispatch_uop_count_o      = count_q;
    assign bus.lane_is_capability_o      = cap_q;
    assign bus.capability_issued_count_o = cap_issued_q;
    assign bus.alu_issue_count_o         = clus_cnt_q[0];
    assign bus.capability_issue_count_o  = clus_cnt_q[1];
    assign bus.lsq_issue_count_o         = clus_cnt_q[2];
    assign bus.async_issue_count_o       = clus_cnt_q[3];

endmodule

// File: tb/tb_decode_rename_dispatch.sv
// Self-checking bench for decode_rename_dispatch: a behavioural model of the
// decode table, rename register and cluster counters is compared against the
// design every falling edge; directed literal checks pin the model.
module tb_decode_rename_dispatch;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    decode_rename_dispatch_if #(.MAX_UOPS(2)) bus ();

    decode_rename_dispatch #(.MAX_UOPS(2)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Tag numbers: 0 INT_ALU 1 PREFIX_SELECT 2 ST_U8 3 PACK_ADD_SAT 4 CAP_JUMP
    // 5 LINK 6 CAP_LOAN_END 7 MEM_PREFETCH 8 LR128.  Clusters: 0 ALU 1 CAP 2 LSQ 3 ASYNC.
    function automatic void m_decode(input logic [23:0] ins, input logic lg,
                                     output int t0, output int t1, output int cnt);
        t0 = 0; t1 = 0; cnt = 0;
        if (!lg) begin
            if (ins[11:4] == 8'hEE)      begin t0 = 1; cnt = 1; end
            else if (ins[11:4] == 8'h89) begin t0 = 2; cnt = 1; end
        end else begin
            case (ins[23:20])
                4'h5: begin t0 = 3; cnt = 1; end
                4'h4: begin t0 = 4; t1 = 5; cnt = 2; end
                4'h6: begin t0 = 7; cnt = 1; end
                4'h9: if (ins[11:0] == 12'hFF1) begin t0 = 6; cnt = 1; end
                4'hC: begin t0 = 8; cnt = 1; end
                default: ;
            endcase
        end
    endfunction

    function automatic int m_cap(input int t);
        return (t == 1 || t == 4 || t == 5 || t == 6) ? 1 : 0;
    endfunction

    function automatic int m_clus(input int t);
        if (m_cap(t) != 0) return 1;
        if (t == 2 || t == 8) return 2;
        if (t == 7) return 3;
        return 0;
    endfunction

    int m_valid = 0;
    int m_t [2] = '{0, 0};
    int m_cnt = 0;
    int m_capiss = 0;
    int m_cc [4] = '{0, 0, 0, 0};

    always @(posedge clk or posedge rst) begin : model_upd
        int t0, t1, c;
        if (rst) begin
            m_valid = 0; m_t[0] = 0; m_t[1] = 0; m_cnt = 0; m_capiss = 0;
            for (int k = 0; k < 4; k++) m_cc[k] = 0;
        end else begin
            m_decode(bus.instr_i, bus.instr_is_long_i, t0, t1, c);
            if (m_valid != 0)
                for (int i = 0; i < m_cnt; i++)
                    m_cc[m_clus(m_t[i])] = (m_cc[m_clus(m_t[i])] + 1) % 65536;
            if (c > 0) begin
                m_valid = 1; m_t[0] = t0; m_t[1] = t1; m_cnt = c;
                m_capiss = (m_capiss + m_cap(t0) + ((c > 1) ? m_cap(t1) : 0)) % 65536;
            end else begin
                m_valid = 0; m_t[0] = 0; m_t[1] = 0; m_cnt = 0;
            end
        end
    end

    always @(negedge clk) begin : compare
        int t0, t1, c;
        int ecap, eclus;
        m_decode(bus.instr_i, bus.instr_is_long_i, t0, t1, c);
        chk("tag0", 32'(bus.uop_tag0_o), t0);
        chk("tag1", 32'(bus.uop_tag1_o), t1);
        chk("count", 32'(bus.uop_count_o), c);
        chk("match", 32'(bus.match_valid_o), (c > 0) ? 1 : 0);
        chk("dispatch_ready", 32'(bus.dispatch_ready_o), rst ? 0 : 1);
        chk("rename_ready", 32'(bus.rename_ready_o), (m_valid == 0 || !rst) ? 1 : 0);
        chk("dispatch_valid", 32'(bus.dispatch_valid_o), m_valid);
        chk("dispatch_uop0", 32'(bus.dispatch_uop0_o), m_t[0]);
        chk("dispatch_uop1", 32'(bus.dispatch_uop1_o), m_t[1]);
        chk("dispatch_count", 32'(bus.dispatch_uop_count_o), m_cnt);
        ecap = 0; eclus = 0;
        for (int i = 0; i < 2; i++) begin
            if (m_valid != 0 && i < m_cnt) begin
                ecap  = ecap | (m_cap(m_t[i]) << i);
                eclus = eclus | (m_clus(m_t[i]) << (2 * i));
            end
        end
        chk("lane_cap", 32'(bus.lane_is_capability_o), ecap);
        chk("lane_cluster", 32'(bus.lane_cluster_o), eclus);
        chk("cap_issued", 32'(bus.capability_issued_count_o), m_capiss);
        chk("alu_cnt", 32'(bus.alu_issue_count_o), m_cc[0]);
        chk("cap_cnt", 32'(bus.capability_issue_count_o), m_cc[1]);
        chk("lsq_cnt", 32'(bus.lsq_issue_count_o), m_cc[2]);
        chk("async_cnt", 32'(bus.async_issue_count_o), m_cc[3]);
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input logic [23:0] ins, input logic lg);
        @(posedge clk);
        #1;
        bus.instr_i         = ins;
        bus.instr_is_long_i = lg;
        @(negedge clk);
        #1;
    endtask

    initial begin
        bus.instr_i         = 24'hFFFFFF;
        bus.instr_is_long_i = 1'b1;
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        @(negedge clk);
        #1;
        chk("lit_reset_valid", 32'(bus.dispatch_valid_o), 0);
        chk("lit_reset_ready", 32'(bus.dispatch_ready_o), 1);
        chk("lit_reset_capiss", 32'(bus.capability_issued_count_o), 0);

        step(24'h000EE8, 1'b0);
        chk("lit_ee8_match", 32'(bus.match_valid_o), 1);
        chk("lit_ee8_tag0", 32'(bus.uop_tag0_o), 1);
        chk("lit_ee8_count", 32'(bus.uop_count_o), 1);
        chk("lit_ee8_rready", 32'(bus.rename_ready_o), 1);
        step(24'hFFFFFF, 1'b1);
        chk("lit_ee8_lanecap", 32'(bus.lane_is_capability_o), 32'b01);
        chk("lit_ee8_cluster", 32'(bus.lane_cluster_o), 32'b0001);

        step(24'h000895, 1'b0);
        chk("lit_895_tag0", 32'(bus.uop_tag0_o), 2);
        step(24'hFFFFFF, 1'b1);
        chk("lit_895_lanecap", 32'(bus.lane_is_capability_o), 0);
        chk("lit_895_cluster", 32'(bus.lane_cluster_o), 32'b0010);

        step(24'h000FFF, 1'b0);
        chk("lit_fff_match", 32'(bus.match_valid_o), 0);
        step(24'hFFFFFF, 1'b1);

        step(24'h400040, 1'b1);
        chk("lit_400_count", 32'(bus.uop_count_o), 2);
        chk("lit_400_tag0", 32'(bus.uop_tag0_o), 4);
        chk("lit_400_tag1", 32'(bus.uop_tag1_o), 5);
        step(24'hFFFFFF, 1'b1);
        chk("lit_400_lanecap", 32'(bus.lane_is_capability_o), 32'b11);
        chk("lit_400_cluster", 32'(bus.lane_cluster_o), 32'b0101);
        chk("lit_400_capiss", 32'(bus.capability_issued_count_o), 3);

        step(24'h500000, 1'b1);
        chk("lit_500_tag0", 32'(bus.uop_tag0_o), 3);
        step(24'hFFFFFF, 1'b1);
        chk("lit_500_cluster", 32'(bus.lane_cluster_o), 0);
        step(24'h900FF1, 1'b1);
        chk("lit_900_tag0", 32'(bus.uop_tag0_o), 6);
        step(24'hFFFFFF, 1'b1);
        chk("lit_900_cluster", 32'(bus.lane_cluster_o), 1);
        step(24'h600000, 1'b1);
        chk("lit_600_tag0", 32'(bus.uop_tag0_o), 7);
        step(24'hFFFFFF, 1'b1);
        chk("lit_600_cluster", 32'(bus.lane_cluster_o), 3);
        step(24'hC00000, 1'b1);
        chk("lit_c00_tag0", 32'(bus.uop_tag0_o), 8);
        step(24'hFFFFFF, 1'b1);
        chk("lit_c00_cluster", 32'(bus.lane_cluster_o), 2);
        step(24'hFFFFFF, 1'b1);
        chk("lit_tot_capiss", 32'(bus.capability_issued_count_o), 4);
        chk("lit_tot_cap", 32'(bus.capability_issue_count_o), 4);
        chk("lit_tot_lsq", 32'(bus.lsq_issue_count_o), 2);
        chk("lit_tot_alu", 32'(bus.alu_issue_count_o), 1);
        chk("lit_tot_async", 32'(bus.async_issue_count_o), 1);

        // Reset while the rename register is occupied.
        step(24'h400040, 1'b1);
        @(posedge clk);
        #2;
        chk("lit_pre_rst_valid", 32'(bus.dispatch_valid_o), 1);
        rst = 1'b1;
        bus.instr_i         = 24'hFFFFFF;
        bus.instr_is_long_i = 1'b1;
        #1;
        chk("lit_rst_valid", 32'(bus.dispatch_valid_o), 0);
        chk("lit_rst_count", 32'(bus.dispatch_uop_count_o), 0);
        chk("lit_rst_lanecap", 32'(bus.lane_is_capability_o), 0);
        chk("lit_rst_cluster", 32'(bus.lane_cluster_o), 0);
        chk("lit_rst_ready", 32'(bus.dispatch_ready_o), 0);
        chk("lit_rst_capiss", 32'(bus.capability_issued_count_o), 0);
        chk("lit_rst_cap", 32'(bus.capability_issue_count_o), 0);
        chk("lit_rst_lsq", 32'(bus.lsq_issue_count_o), 0);
        chk("lit_rst_alu", 32'(bus.alu_issue_count_o), 0);
        chk("lit_rst_async", 32'(bus.async_issue_count_o), 0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;

        step(24'h000EE8, 1'b0);
        step(24'hFFFFFF, 1'b1);
        chk("lit_post_capiss", 32'(bus.capability_issued_count_o), 1);
        step(24'hFFFFFF, 1'b1);
        chk("lit_post_cap", 32'(bus.capability_issue_count_o), 1);

        repeat (2) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_rename_dispatch.md
Name: decode_rename_dispatch

Overview:
- Front-end slice: combinational instruction decoder, one-entry rename pipeline register, and a dispatch classifier with per-cluster issue counters.
- Turns a 12-bit short or 24-bit long instruction into up to two micro-op tags.
- Marks capability lanes and routes each lane to an execution cluster (ALU, capability, LSQ, async).
- Counts issued micro-ops for bring-up smoke testing.

Parameters:
- MAX_UOPS, 2, lanes per instruction; only 2 is supported.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- instr_i  in  24  instruction; short form uses [11:0]
- instr_is_long_i  in  1  1 = 24-bit long form
- uop_tag0_o / uop_tag1_o  out  uop_tag_t  decoded tags (combinational)
- uop_count_o  out  2  decoded uop count, 0..2
- match_valid_o  out  1  encoding recognised
- rename_ready_o  out  1  rename accepts a decode
- dispatch_valid_o  out  1  rename register holds an instruction
- dispatch_uop0_o / dispatch_uop1_o  out  uop_tag_t  registered tags
- dispatch_uop_count_o  out  2  registered count
- dispatch_ready_o  out  1  dispatch accepts
- lane_is_capability_o  out  MAX_UOPS  registered per-lane capability flag
- lane_cluster_o  out  2*MAX_UOPS  lane i at [2i+:2], cluster_sel_e
- capability_issued_count_o  out  16  capability uops accepted by rename
- alu_issue_count_o, capability_issue_count_o, lsq_issue_count_o, async_issue_count_o  out  16 each  uops issued per cluster

Behaviour:
- Decode is purely combinational. No match drives count 0, both tags UOP_INT_ALU, and match_valid 0. Unused tag1 is UOP_INT_ALU.
- Short-form decode (instr_is_long_i = 0, only [11:0] examined):
  - [11:4] = 8'hEE -> UOP_PREFIX_SELECT, count 1
  - [11:4] = 8'h89 -> UOP_ST_U8, count 1
  - anything else (e.g. 12'hFFF) -> no match
- Long-form decode (instr_is_long_i = 1, selected on [23:20]):
  - 4'h5 -> UOP_PACK_ADD_SAT, count 1
  - 4'h4 -> {UOP_CAP_JUMP, UOP_LINK}, count 2
  - 4'h6 -> UOP_MEM_PREFETCH, count 1
  - 4'h9 with [11:0] = 12'hFF1 -> UOP_CAP_LOAN_END, count 1
  - 4'hC -> UOP_LR128, count 1
  - anything else (e.g. 24'hFFFFFF) -> no match
- Capability uops: PREFIX_SELECT, CAP_JUMP, LINK, CAP_LOAN_END.
- Cluster map:
  - capability uops -> CLUSTER_CAPABILITY
  - ST_U8, LR128 -> CLUSTER_LSQ
  - MEM_PREFETCH -> CLUSTER_ASYNC
  - all others -> CLUSTER_ALU
- dispatch_ready_o = 1 whenever rst_i is low; 0 during reset.
- rename_ready_o = !dispatch_valid_o || dispatch_ready_o. It is combinational and high in the same cycle a decode is presented.
- Rename register, updated at posedge clk_i:
  - Accept when match_valid_o && rename_ready_o.
  - On accept: dispatch_valid_o <= 1; tags, count and lane_is_capability are captured.
  - Lanes with index >= count get capability flag 0 and tag UOP_INT_ALU.
  - With no accept and dispatch accepted: dispatch_valid_o <= 0; tags, count and flags clear to 0.
  - capability_issued_count_o increases by the number of capability lanes among the accepted lanes (0..2).
- Dispatch:
  - lane_cluster_o is combinational from the registered tags, so it is valid one clock after decode.
  - Lanes >= count and the invalid state show CLUSTER_ALU.
  - At posedge with dispatch_valid_o && dispatch_ready_o, each cluster counter increases by its lane count among lanes < dispatch_uop_count_o.
- Timing: an instruction decoded in cycle N appears on dispatch_* and lane_* after edge N. Its cluster counters update at edge N+1.
- All counters are 16-bit and wrap modulo 2^16.
- Reset, asynchronous and honoured mid-operation: all registers, counters and outputs go to 0, clusters to CLUSTER_ALU, dispatch_valid_o 0. Decode outputs stay combinational.

Decomposition:
- uop_pkg: uop_tag_t, 6-bit enum:
  - INT_ALU = 0, PREFIX_SELECT = 1, ST_U8 = 2, PACK_ADD_SAT = 3, CAP_JUMP = 4
  - LINK = 5, CAP_LOAN_END = 6, MEM_PREFETCH = 7, LR128 = 8
- cluster_pkg: cluster_sel_e, 2-bit: ALU = 0, CAPABILITY = 1, LSQ = 2, ASYNC = 3. Also holds the functions is_capability(uop) and cluster_of(uop).
- decode_table_pkg: the encoding match constants.
- One natural sub-module: decode_table, the combinational decoder. Rename and dispatch logic live inline in the top.

Test Plan:
- Short 12'hEE8 -> match 1, count 1, tag PREFIX_SELECT, rename_ready 1. Next cycle: lane0 capability 1, cluster CAPABILITY.
- Short 12'h895 -> ST_U8, lane0 capability 0, cluster LSQ. Idle 12'hFFF -> match 0, no counter change.
- Long 24'h400040 -> count 2, {CAP_JUMP, LINK}. Both lanes capability 1 and cluster CAPABILITY; capability_issued_count +2.
- Long 24'h500000, 24'h900FF1, 24'h600000, 24'hC00000 -> PACK_ADD_SAT/ALU, CAP_LOAN_END/CAPABILITY, MEM_PREFETCH/ASYNC, LR128/LSQ.
- Full sequence of all scenarios above, each followed by an idle 24'hFFFFFF:
  - capability_issued 4
  - capability_issue 4
  - lsq 2
  - alu 1
  - async 1
- Assert rst_i while dispatch_valid_o = 1 -> all outputs 0 immediately, counters 0. The first post-reset decode counts normally.
